// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: button indices, event id width and type.
package vm_pkg;

  localparam int unsigned N_BTN_DEFAULT = 4;
  localparam int unsigned IDX_W         = $clog2(N_BTN_DEFAULT);

  localparam int unsigned BTN_COIN5  = 0;
  localparam int unsigned BTN_COIN10 = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_CANCEL = 3;

  typedef logic [IDX_W-1:0] evt_id_t;

endpackage

// File: rtl/button_event_arbiter_if.sv
// Press-event handshake between the button arbiter (master) and the control FSM (slave).
interface button_event_arbiter_if
  import vm_pkg::*;
#(
  parameter int unsigned N_BTN = N_BTN_DEFAULT
);
  localparam int unsigned ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (output evt_valid, output evt_id, input  evt_ready);
  modport slave  (input  evt_valid, input  evt_id, output evt_ready);
endinterface

// File: rtl/button_event_arbiter_fifo.sv
// event_fifo: DEPTH x WIDTH synchronous FIFO with occupancy count, clear and combinational head.
module event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

  assign dout = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/button_event_arbiter.sv
// Edge-detects debounced buttons, round-robin arbitrates pending presses into an event FIFO.
// Optional auto-repeat of held buttons is enabled by defining BTN_AUTOREPEAT_EN.
module button_event_arbiter
  import vm_pkg::*;
#(
  parameter int unsigned N_BTN         = N_BTN_DEFAULT,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned REPEAT_CYCLES = 50000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_BTN-1:0]          debounced,
  input  logic                      clear,
  button_event_arbiter_if.master    evt,
  output logic [N_BTN-1:0]          pending,
  output logic                      drop_flag,
  output logic [$clog2(DEPTH):0]    fifo_count
);
  localparam int unsigned ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int unsigned CW   = $clog2(DEPTH) + 1;

  logic [N_BTN-1:0] prev;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] merged;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  head_id;
  logic             found;
  logic             do_grant;
  logic             pop;
  logic             can_accept;
  int unsigned      slot;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES) + 1;

  logic [RW-1:0]    rpt_cnt [N_BTN];
  logic [N_BTN-1:0] inject;

  always_comb begin
    inject = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      inject[i] = debounced[i] && prev[i] && (rpt_cnt[i] == RW'(REPEAT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_BTN; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (clear || !(debounced[i] && prev[i]) || inject[i]) rpt_cnt[i] <= '0;
        else                                                  rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
      end
    end
  end

  assign rise = (debounced & ~prev) | inject;
`else
  assign rise = debounced & ~prev;
`endif

  assign pop        = evt.evt_valid && evt.evt_ready;
  assign can_accept = (fifo_count < CW'(DEPTH)) || pop;

  // First pending bit at or after ptr, wrapping modulo N_BTN.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    slot    = 0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      slot = 32'(ptr) + k;
      if (slot >= N_BTN) slot = slot - N_BTN;
      if (!found && pending[slot]) begin
        found   = 1'b1;
        gnt_idx = slot[ID_W-1:0];
      end
    end
  end

  assign do_grant = found && can_accept && !clear;
  assign grant    = do_grant ? (N_BTN'(1) << gnt_idx) : '0;
  assign merged   = rise & pending & ~grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev      <= '1;
      pending   <= '0;
      ptr       <= '0;
      drop_flag <= 1'b0;
    end else begin
      prev <= debounced;
      if (clear) begin
        pending <= '0;
        ptr     <= '0;
      end else begin
        pending   <= (pending & ~grant) | rise;
        drop_flag <= drop_flag | (|merged);
        if (do_grant) begin
          ptr <= (gnt_idx == ID_W'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

  event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ID_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clear (clear),
    .push  (do_grant),
    .din   (gnt_idx),
    .pop   (pop),
    .dout  (head_id),
    .count (fifo_count)
  );

  assign evt.evt_valid = (fifo_count != '0);
  assign evt.evt_id    = head_id;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter: expected event ids are queued by stimulus, popped by a monitor.
module tb_button_event_arbiter;
  import vm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] debounced = 4'b0001;
  logic       clear = 1'b0;
  logic [3:0] pending;
  logic       drop_flag;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;
  int unsigned exp_q[$];

  button_event_arbiter_if #(.N_BTN(4)) ev();

  button_event_arbiter #(
    .N_BTN         (4),
    .DEPTH         (4),
    .REPEAT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .debounced  (debounced),
    .clear      (clear),
    .evt        (ev.master),
    .pending    (pending),
    .drop_flag  (drop_flag),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && ev.evt_valid && ev.evt_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got id %0d, required no event", ev.evt_id);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        if (32'(ev.evt_id) != e) begin
          bad++;
          $display("FAIL pop_id: got %0d, required %0d", ev.evt_id, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (k < 40 && !(fifo_count == 0 && pending == 0 && !ev.evt_valid)) begin
      tick();
      k++;
    end
    tick();
    total++;
    if (k >= 40) begin
      bad++;
      $display("FAIL %s_drain_timeout: got count=%0d pending=%b, required empty", name, fifo_count, pending);
    end
  endtask

  initial begin
    ev.evt_ready = 1'b0;
    // Reset with button 0 held
    tick(3);
    chk("rst_valid", 32'(ev.evt_valid), 0);
    chk("rst_id", 32'(ev.evt_id), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_drop", 32'(drop_flag), 0);
    chk("rst_count", 32'(fifo_count), 0);
    rst_n = 1'b1;
    tick(3);
    chk("held_no_pending", 32'(pending), 0);
    chk("held_no_valid", 32'(ev.evt_valid), 0);
    debounced = 4'b0000;
    tick();
    debounced = 4'b0001;
    tick();
    debounced = 4'b0000;
    chk("t1_pending", 32'(pending), 32'h1);
    chk("t1_valid_early", 32'(ev.evt_valid), 0);
    exp_q.push_back(BTN_COIN5);
    tick();
    chk("t1_valid", 32'(ev.evt_valid), 1);
    chk("t1_id", 32'(ev.evt_id), 0);
    ev.evt_ready = 1'b1;
    wait_idle("t1");

    // All four pressed at once from pointer 0
    clear = 1'b1;
    tick();
    clear = 1'b0;
    debounced = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    tick();
    debounced = 4'b0000;
    wait_idle("t2");
    chk("t2_drop", 32'(drop_flag), 0);

    // Six presses against a stalled consumer
    ev.evt_ready = 1'b0;
    debounced = 4'b1111;
    tick();
    debounced = 4'b0000;
    tick(5);
    chk("t3_full", 32'(fifo_count), 4);
    debounced = 4'b0011;
    tick();
    debounced = 4'b0000;
    tick();
    chk("t3_count", 32'(fifo_count), 4);
    chk("t3_pending", 32'(pending), 32'h3);
    chk("t3_drop", 32'(drop_flag), 0);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
    ev.evt_ready = 1'b1;
    wait_idle("t3");
    chk("t3_drop_after", 32'(drop_flag), 0);

    // Button 2 merged while pending and FIFO full
    ev.evt_ready = 1'b0;
    debounced = 4'b1111;
    tick();
    debounced = 4'b0000;
    tick(4);
    debounced = 4'b0100;
    tick();
    debounced = 4'b0000;
    tick();
    debounced = 4'b0100;
    tick();
    debounced = 4'b0000;
    tick();
    chk("t4_drop", 32'(drop_flag), 1);
    chk("t4_pending", 32'(pending), 32'h4);
    chk("t4_count", 32'(fifo_count), 4);
    exp_q.push_back(BTN_SELECT); exp_q.push_back(BTN_CANCEL); exp_q.push_back(BTN_COIN5);
    exp_q.push_back(BTN_COIN10); exp_q.push_back(BTN_SELECT);
    ev.evt_ready = 1'b1;
    wait_idle("t4");
    chk("t4_drop_kept", 32'(drop_flag), 1);

    // Clear with three queued and button 2 pending
    ev.evt_ready = 1'b0;
    debounced = 4'b1011;
    tick();
    debounced = 4'b0000;
    tick(2);
    debounced = 4'b0100;
    tick();
    debounced = 4'b0000;
    chk("t5_count", 32'(fifo_count), 3);
    chk("t5_pending", 32'(pending), 32'h4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_valid", 32'(ev.evt_valid), 0);
    chk("t5_pending_clr", 32'(pending), 0);
    chk("t5_count_clr", 32'(fifo_count), 0);
    chk("t5_drop", 32'(drop_flag), 1);
    tick(2);
    chk("t5_stays_empty", 32'(ev.evt_valid), 0);

    // Reset mid-transfer
    debounced = 4'b0001;
    tick();
    debounced = 4'b0000;
    tick(2);
    chk("t7_queued", 32'(fifo_count), 1);
    rst_n = 1'b0;
    #2;
    chk("t7_valid", 32'(ev.evt_valid), 0);
    chk("t7_count", 32'(fifo_count), 0);
    chk("t7_drop", 32'(drop_flag), 0);
    tick();
    rst_n = 1'b1;
    tick(3);
    chk("t7_no_event", 32'(ev.evt_valid), 0);

`ifdef BTN_AUTOREPEAT_EN
    // Auto-repeat of button 1 held for 30 cycles
    ev.evt_ready = 1'b1;
    debounced = 4'b0010;
    for (int i = 0; i < 4; i++) exp_q.push_back(BTN_COIN10);
    tick(30);
    debounced = 4'b0000;
    wait_idle("t6");
`endif

    tick(2);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Sequences the four debounced button levels (coin/select/cancel keys) into a single ordered stream of press events for the vending-machine control FSM.
- Detects the rising edge of each debounced line and holds it as a pending request.
- A round-robin arbiter grants at most one pending request per cycle into a small event FIFO.
- The FSM consumes events over a valid/ready handshake.

Parameters:
- N_BTN, 4, number of debounced button inputs; legal range 2..8.
- DEPTH, 4, event FIFO depth; power of two, at least 2.
- REPEAT_CYCLES, 50000000, auto-repeat period in clk cycles; used only with BTN_AUTOREPEAT_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- debounced  in  N_BTN  debounced button levels, synchronous to clk.
- clear  in  1  synchronous flush of pending requests and FIFO.
- evt_valid  out  1  FIFO head holds an event.
- evt_id  out  clog2(N_BTN)  button index of the head event.
- evt_ready  in  1  consumer accepts the head event.
- pending  out  N_BTN  requests not yet granted into the FIFO.
- drop_flag  out  1  sticky; a press was merged or lost.
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - evt_valid=0, evt_id=0, pending=0, drop_flag=0, fifo_count=0.
  - Round-robin pointer=0.
  - Edge-history register prev=all ones, so a button held through reset produces no event until it is released and pressed again.
- Edge detect: rise[i] = debounced[i] & ~prev[i]. prev <= debounced every cycle.
- Pending update per bit: pending[i] <= (pending[i] & ~grant[i]) | rise[i].
  - Rise on a bit that is already pending and not granted this cycle: merged; drop_flag <= 1.
  - Rise and grant on the same bit in the same cycle: bit stays set; the new press is kept; no drop.
- Arbiter:
  - Grant is issued when pending != 0 and the FIFO can accept (fifo_count < DEPTH, or fifo_count == DEPTH with a pop in the same cycle).
  - Search starts at the pointer and wraps modulo N_BTN; the first set bit is granted.
  - The pointer moves to granted index + 1 (mod N_BTN). No grant leaves the pointer unchanged.
  - At most one grant per cycle.
- FIFO:
  - Push writes the granted index. Pop occurs when evt_valid & evt_ready.
  - Push and pop in the same cycle leaves the count unchanged, including when full.
  - evt_valid = (fifo_count != 0). evt_id is the head entry, stable while evt_valid=1 and no pop.
  - Read and write pointers wrap modulo DEPTH.
- Latency: rise sampled at edge k → pending set after k → pushed at k+1 → evt_valid=1 after k+1 when the FIFO was empty and not blocked. Two cycles, press to visible event.
- FIFO full with no pop: requests wait in pending. They are not lost unless merged.
- clear=1 (synchronous): pending=0, FIFO emptied, pointer=0. drop_flag and prev are kept. Same-cycle rises are discarded. clear has priority over push and pop.
- drop_flag clears only on reset.
- Reset asserted mid-transfer: the FIFO contents are lost; no partial event appears after reset.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - A per-button counter runs while debounced[i]=1 and prev[i]=1.
  - Reaching REPEAT_CYCLES-1 injects rise[i] and restarts the count from 0.
  - Release or clear zeroes the counter.
  - Injected presses follow the same merge/drop rules as real presses.
- Undefined: no counters are instantiated; only real edges create events.

Decomposition:
- Shared package vm_pkg:
  - Button index constants BTN_COIN5=0, BTN_COIN10=1, BTN_SELECT=2, BTN_CANCEL=3.
  - Index width localparam.
  - evt_id typedef.
- Sub-module event_fifo: parameterised DEPTH x width synchronous FIFO with count, push/pop/clear, combinational head output. Also reusable for the dispense queue.
- Arbiter and edge detect stay in the top module.

Test Plan:
1. Reset with debounced=4'b0001 held, then released and re-pressed: no event while held; after the re-press, evt_valid=1 with evt_id=0 two cycles after the rise.
2. debounced 0→4'b1111 in one cycle with evt_ready=1: evt_ids emerge 0,1,2,3 on consecutive pops; pointer ends at 0; drop_flag=0.
3. evt_ready=0 with 6 distinct presses, DEPTH=4: fifo_count saturates at 4 and two bits stay in pending. Raising evt_ready drains 6 events in round-robin order, with no drop.
4. Button 2 pressed twice while pending[2]=1 and the FIFO is full: one event for button 2 is delivered and drop_flag=1 stays set until reset.
5. clear pulsed with fifo_count=3 and pending=4'b0100: next cycle evt_valid=0, pending=0, fifo_count=0, and drop_flag is unchanged.
6. With BTN_AUTOREPEAT_EN and REPEAT_CYCLES=8, button 1 held for 30 cycles: one edge event plus 3 repeat events, each with evt_id=1.
